// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and default width for the serial arithmetic blocks
package serial_arith_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_adder_s.sv
// full_adder_s: single-bit full adder
module full_adder_s (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder time-sharing one full adder
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [1:0]       state;
  logic [WIDTH-1:0] sha, shb, res, res_nx;
  logic             carry, fa_s, fa_c, last;
  logic [CNT_W-1:0] cnt;
  full_adder_s u_fa (.a(sha[0]), .b(shb[0]), .cin(carry), .sum(fa_s), .cout(fa_c));
  // result fills from the top so bit 0 lands in res[0] after WIDTH shifts
  assign res_nx = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last   = cnt == CNT_W'(WIDTH - 1);
  assign busy   = (state == ST_RUN) || (state == ST_DONE);
  assign done   = state == ST_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sha   <= '0;
      shb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        sha   <= a;
        shb   <= b;
        carry <= cin;
        cnt   <= '0;
        res   <= '0;
        state <= ST_RUN;
      end
    end else if (state == ST_RUN) begin
      sha   <= sha >> 1;
      shb   <= shb >> 1;
      carry <= fa_c;
      res   <= res_nx;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        state <= ST_DONE;
        sum   <= res_nx;
        cout  <= fa_c;
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for 8-bit and 1-bit serial adder instances
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always @(negedge clk) begin
    if (done8) begin
      total++;
      if (q8.size() == 0) $display("FAIL done8_unexpected got {cout,sum}=%h expected no done", {cout8, sum8});
      else begin
        logic [8:0] e;
        e = q8.pop_front();
        if ({cout8, sum8} !== e) $display("FAIL result8 got %h expected %h", {cout8, sum8}, e);
        else passed++;
      end
    end
    if (done1) begin
      total++;
      if (q1.size() == 0) $display("FAIL done1_unexpected got {cout,sum}=%b expected no done", {cout1, sum1});
      else begin
        logic [1:0] e;
        e = q1.pop_front();
        if ({cout1, sum1} !== e) $display("FAIL result1 got %b expected %b", {cout1, sum1}, e);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) $display("FAIL reset8 got %h expected 0", {busy8, done8, cout8, sum8});
    else passed++;
    total++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) $display("FAIL reset1 got %b expected 0", {busy1, done1, cout1, sum1});
    else passed++;
  endtask

  task automatic test_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    tick();
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) $display("FAIL busy_after_start got busy=%b done=%b expected 1/0", busy8, done8);
    else passed++;
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 8) $display("FAIL done_latency got %0d edges expected 8", n);
    else passed++;
    tick();
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) $display("FAIL done_one_cycle got done=%b busy=%b expected 0/0", done8, busy8);
    else passed++;
  endtask

  task automatic test_ignore_start();
    int dones;
    a8 = 8'h22; b8 = 8'h33; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h055);
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    a8 = 8'h10; b8 = 8'h10; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) dones++;
    end
    total++;
    if (dones !== 1) $display("FAIL ignore_done_count got %0d expected 1", dones);
    else passed++;
  endtask

  task automatic test_back_to_back();
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    repeat (3) q8.push_back(9'h081);
    tick();
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 20) start8 = 1'b0;
      total++;
      if (done8 !== (n == 8 || n == 18 || n == 28)) $display("FAIL b2b_done n=%0d got %b", n, done8);
      else passed++;
      if (n >= 8) begin
        total++;
        if (sum8 !== 8'h81) $display("FAIL b2b_sum_hold n=%0d got %h expected 81", n, sum8);
        else passed++;
      end
    end
  endtask

  task automatic test_abort();
    int dones;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h010);
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q8.delete();
    total++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) $display("FAIL abort_clear got %h expected 0", {busy8, done8, cout8, sum8});
    else passed++;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL abort_no_done got %0d expected 0", dones);
    else passed++;
    test_add(8'h0F, 8'h01, 1'b0);
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
      q1.push_back(2'(v[0]) + 2'(v[1]) + 2'(v[2]));
      tick();
      start1 = 1'b0;
      tick();
      total++;
      if (done1 !== 1'b1) $display("FAIL w1_done i=%0d got %b expected 1", i, done1);
      else passed++;
      tick();
      total++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL w1_idle i=%0d got done=%b busy=%b expected 0/0", i, done1, busy1);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add(8'd5, 8'd3, 1'b0);
    test_add(8'hFF, 8'h01, 1'b0);
    test_add(8'hFF, 8'hFF, 1'b1);
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_width1();
    tick();
    total++;
    if (q8.size() + q1.size() !== 0) $display("FAIL pending_results got %0d expected 0", q8.size() + q1.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller. Time-shares one full_adder_s instance over WIDTH cycles to add two WIDTH-bit operands.
- Sequences operand shifting, carry feedback and result assembly behind a start/busy/done handshake.
- Area-reduced alternative to a ripple-carry adder in the arithmetic circuits group.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH)+1, width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; the result is valid in this cycle.
- sum  output  WIDTH  registered result; holds until the next result.
- cout  output  1  registered final carry; holds with sum.

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and counter cleared.
- Reset takes priority over every other event. Asserting it mid-RUN aborts the operation: no done pulse, and sum/cout are cleared.
- States: IDLE, RUN, DONE. Binary encoding.
- IDLE:
  - On an edge with start=1: load shA=a, shB=b, carry=cin, cnt=0, res=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - The full adder sees shA[0], shB[0], carry.
  - res shifts right with the adder sum entering at bit WIDTH-1.
  - carry takes the adder cout.
  - shA and shB shift right with zero fill.
  - cnt increments.
  - On the edge where cnt==WIDTH-1 (the last bit): go to DONE. Register sum to the final res value and cout to the final carry.
- DONE: done=1 for exactly one cycle, then go to IDLE on the next edge.
- Latency: start accepted at edge k, so sum/cout update and done rises after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored. It is not queued, and operands are not re-captured.
- Changes on a, b or cin after the capture edge have no effect on the result in flight.
- sum/cout change only on the RUN-to-DONE edge or on reset. They are stable through IDLE and through the next RUN.
- WIDTH=1: RUN lasts a single edge, then DONE.
- Arithmetic is modulo 2^WIDTH, with overflow reported on cout. Result matches a+b+cin exactly.

Decomposition:
- Shared package serial_arith_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default width constant.
- One sub-module: the existing full_adder_s (ports a, b, cin, sum, cout), instantiated once as the datapath.
- Everything else (FSM, shift registers, counter, output registers) lives inline in serial_adder_ctrl.

Test Plan:
- WIDTH=8, reset, then start with a=8'd5, b=8'd3, cin=0 -> busy=1 on the next cycle; done pulses exactly 8 edges after the start edge; sum=8'd8, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Mid-RUN: pulse start with new operands a=8'h10, b=8'h10 -> ignored; result is the first operation's, and only one done pulse occurs.
- Hold start=1 continuously with fixed operands -> operations are accepted at edges k, k+10, k+20; done asserts once per operation; sum is constant between done pulses.
- rst=1 at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done follows; a fresh start then completes normally.
- WIDTH=1 instance, all 8 input combinations of a, b, cin -> done one edge after start; {cout,sum} equals a+b+cin in every case.
